// File: rtl/mem_dump_reader.sv
// Debug memory dump: sweeps NUM_WORDS consecutive words of data memory and
// streams each word MSB-first as four bytes over a valid/ready byte link.
module mem_dump_reader #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_WORDS  = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [1:0]            SIZE_WORD  = 2'b11
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_dataread,
   input  logic                  i_tx_ready,
   output logic [DATA_WIDTH-1:0] o_address,
   output logic                  o_memread,
   output logic [1:0]            o_sizemem,
   output logic                  o_signedmem,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int                    IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_WORDS - 1);
   localparam logic [DATA_WIDTH-1:0] WORD_STRIDE = DATA_WIDTH'(4);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_SEND,
      ST_DONE
   } state_t;

   state_t                  state;
   logic [IDX_W-1:0]        word_idx;
   logic [1:0]              byte_cnt;
   logic [DATA_WIDTH-1:0]   shift_reg;

   assign o_sizemem   = SIZE_WORD;
   assign o_signedmem = 1'b0;
   // The outgoing byte is always the top of the shift register, so it is
   // held stable for free while the sink stalls.
   assign o_tx_data   = shift_reg[DATA_WIDTH-1 -: 8];

   // NOTE: every state bit and output flag is assigned with <= so all of them
   // update together at the edge; blocking assignments here would let later
   // statements see half-updated values and break the registered outputs.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         word_idx   <= '0;
         byte_cnt   <= '0;
         // NOTE: the datapath register is reset as well so o_tx_data reads 0
         // out of reset instead of X.
         shift_reg  <= '0;
         o_address  <= BASE_ADDR;
         o_memread  <= 1'b0;
         o_tx_valid <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state     <= ST_ADDR;
                  word_idx  <= '0;
                  o_address <= BASE_ADDR;
                  o_memread <= 1'b1;
                  o_busy    <= 1'b1;
               end
            end

            ST_ADDR: begin
               shift_reg  <= i_dataread;
               byte_cnt   <= '0;
               o_memread  <= 1'b0;
               o_tx_valid <= 1'b1;
               state      <= ST_SEND;
            end

            ST_SEND: begin
               if (o_tx_valid && i_tx_ready) begin
                  shift_reg <= shift_reg << 8;
                  byte_cnt  <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     o_tx_valid <= 1'b0;
                     if (word_idx == LAST_IDX) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                     end else begin
                        // Address tracks BASE_ADDR + 4*index, wrapping modulo 2^DATA_WIDTH.
                        word_idx  <= word_idx + IDX_W'(1);
                        o_address <= o_address + WORD_STRIDE;
                        o_memread <= 1'b1;
                        state     <= ST_ADDR;
                     end
                  end
               end
            end

            ST_DONE: begin
               o_address <= BASE_ADDR;
               state     <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: a queue-of-expected-cycles model checked every
// cycle, plus directed scenarios with literal byte/timing expectations.
module tb_mem_dump_reader;

   localparam logic [31:0] BASE_A = 32'h0000_0000;
   localparam logic [31:0] BASE_B = 32'h0000_0040;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT A: NUM_WORDS=2, BASE=0 ----------------
   logic        start_a, ready_a;
   logic [31:0] dataread_a, address_a;
   logic        memread_a, signedmem_a, txvalid_a, busy_a, done_a;
   logic [1:0]  sizemem_a;
   logic [7:0]  txdata_a;
   logic [31:0] mem_a [2];
   assign dataread_a = mem_a[address_a[2]];

   mem_dump_reader #(.DATA_WIDTH(32), .NUM_WORDS(2), .BASE_ADDR(BASE_A), .SIZE_WORD(2'b11)) dut_a (
      .i_clock(clk), .i_reset(rst), .i_start(start_a), .i_dataread(dataread_a),
      .i_tx_ready(ready_a), .o_address(address_a), .o_memread(memread_a),
      .o_sizemem(sizemem_a), .o_signedmem(signedmem_a), .o_tx_data(txdata_a),
      .o_tx_valid(txvalid_a), .o_busy(busy_a), .o_done(done_a));

   // ---------------- DUT B: NUM_WORDS=1, BASE=0x40 ----------------
   logic        start_b, ready_b;
   logic [31:0] dataread_b, address_b;
   logic        memread_b, signedmem_b, txvalid_b, busy_b, done_b;
   logic [1:0]  sizemem_b;
   logic [7:0]  txdata_b;
   assign dataread_b = (address_b == BASE_B) ? 32'hDEAD_BEEF : 32'h0;

   mem_dump_reader #(.DATA_WIDTH(32), .NUM_WORDS(1), .BASE_ADDR(BASE_B), .SIZE_WORD(2'b11)) dut_b (
      .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_dataread(dataread_b),
      .i_tx_ready(ready_b), .o_address(address_b), .o_memread(memread_b),
      .o_sizemem(sizemem_b), .o_signedmem(signedmem_b), .o_tx_data(txdata_b),
      .o_tx_valid(txvalid_b), .o_busy(busy_b), .o_done(done_b));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- Reference model for DUT A ----------------
   // A sweep is a list of expected cycles: one address cycle per word, four
   // byte slots (held until the sink accepts), then one done cycle.
   typedef enum {K_ADDR, K_BYTE, K_DONE} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] val;
   } slot_t;
   slot_t exp_q[$];

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         exp_q.delete();
      end else if (exp_q.size() == 0) begin
         if (start_a) begin
            for (int w = 0; w < 2; w++) begin
               exp_q.push_back('{K_ADDR, BASE_A + 32'(4 * w)});
               for (int b = 3; b >= 0; b--)
                  exp_q.push_back('{K_BYTE, (mem_a[w] >> (8 * b)) & 32'hFF});
            end
            exp_q.push_back('{K_DONE, 32'h0});
         end
      end else if (exp_q[0].kind != K_BYTE || ready_a) begin
         void'(exp_q.pop_front());
      end
   end

   // ---------------- Per-cycle compare and logging for DUT A ----------------
   logic [7:0] rx_q[$];
   int         done_cnt_a     = 0;
   int         done_cyc_a     = 0;
   int         first_addr_cyc = -1;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         logic e_busy, e_mem, e_val, e_done;
         e_busy = (exp_q.size() > 0) && (exp_q[0].kind != K_DONE);
         e_mem  = (exp_q.size() > 0) && (exp_q[0].kind == K_ADDR);
         e_val  = (exp_q.size() > 0) && (exp_q[0].kind == K_BYTE);
         e_done = (exp_q.size() > 0) && (exp_q[0].kind == K_DONE);
         check("a_busy",    32'(busy_a),    32'(e_busy));
         check("a_memread", 32'(memread_a), 32'(e_mem));
         check("a_valid",   32'(txvalid_a), 32'(e_val));
         check("a_done",    32'(done_a),    32'(e_done));
         check("a_size",    32'(sizemem_a), 32'd3);
         check("a_signed",  32'(signedmem_a), 32'd0);
         if (e_mem) check("a_address", address_a, exp_q[0].val);
         if (e_val) check("a_txdata", 32'(txdata_a), exp_q[0].val);
         if (txvalid_a && ready_a) rx_q.push_back(txdata_a);
         if (memread_a && first_addr_cyc < 0) first_addr_cyc = cyc;
         if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
         end
      end
   end

   // ---------------- Logging for DUT B ----------------
   logic [7:0] rxb_q[$];
   int         last_xfer_b   = -1;
   int         done_cyc_b    = -1;
   int         done_cnt_b    = 0;
   int         memread_cnt_b = 0;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (txvalid_b && ready_b) begin
            rxb_q.push_back(txdata_b);
            last_xfer_b = cyc;
         end
         if (memread_b) begin
            memread_cnt_b++;
            check("b_address", address_b, BASE_B);
         end
         if (done_b) begin
            done_cyc_b = cyc;
            done_cnt_b++;
         end
         check("b_size", 32'(sizemem_b), 32'd3);
      end
   end

   logic [7:0] bytes_ab [8];
   initial bytes_ab = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

   task automatic check_rx_ab(input string name);
      check({name, "_count"}, 32'(rx_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < rx_q.size(); i++)
         check(name, 32'(rx_q[i]), 32'(bytes_ab[i]));
   endtask

   task automatic clear_log();
      rx_q.delete();
      done_cnt_a     = 0;
      first_addr_cyc = -1;
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string name);
      int prev;
      prev = done_cnt_a;
      for (int i = 0; i < 200 && done_cnt_a == prev; i++) tick();
      check(name, 32'(done_cnt_a > prev), 32'd1);
      repeat (3) tick();
   endtask

   initial begin
      rst = 1'b1; start_a = 1'b0; ready_a = 1'b1; start_b = 1'b0; ready_b = 1'b1;
      mem_a[0] = 32'h1122_3344;
      mem_a[1] = 32'hAABB_CCDD;
      #12;
      check("rst_a_busy",    32'(busy_a),    32'd0);
      check("rst_a_valid",   32'(txvalid_a), 32'd0);
      check("rst_a_memread", 32'(memread_a), 32'd0);
      check("rst_a_done",    32'(done_a),    32'd0);
      check("rst_a_address", address_a,      BASE_A);
      check("rst_a_size",    32'(sizemem_a), 32'd3);
      check("rst_b_address", address_b,      BASE_B);
      #10 rst = 1'b0;
      repeat (2) tick();

      // 1: basic two-word dump with the sink always ready
      clear_log();
      pulse_start_a();
      wait_done_a("t1_done_seen");
      check_rx_ab("t1_byte");
      check("t1_done_count", 32'(done_cnt_a), 32'd1);
      check("t1_sweep_cycles", 32'(done_cyc_a - first_addr_cyc + 1), 32'd11);

      // 2: three-cycle stall on byte 2
      clear_log();
      pulse_start_a();
      tick();
      tick();
      ready_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #3;
         check("t2_stall_data",  32'(txdata_a),  32'h22);
         check("t2_stall_valid", 32'(txvalid_a), 32'd1);
         tick();
      end
      ready_a = 1'b1;
      wait_done_a("t2_done_seen");
      check_rx_ab("t2_byte");
      check("t2_done_count", 32'(done_cnt_a), 32'd1);

      // 3/4: start re-pulsed mid-sweep and during DONE
      clear_log();
      pulse_start_a();
      repeat (3) tick();
      pulse_start_a();
      for (int i = 0; i < 50 && !done_a; i++) tick();
      check("t4_done_reached", 32'(done_a), 32'd1);
      pulse_start_a();
      repeat (15) tick();
      check_rx_ab("t4_byte");
      check("t4_done_count", 32'(done_cnt_a), 32'd1);
      check("t4_idle_busy",  32'(busy_a),     32'd0);

      // 5: asynchronous reset while byte 3 of the second word is offered
      clear_log();
      pulse_start_a();
      repeat (8) tick();
      check("t5_pre_data", 32'(txdata_a), 32'hCC);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_valid",   32'(txvalid_a), 32'd0);
      check("t5_rst_busy",    32'(busy_a),    32'd0);
      check("t5_rst_memread", 32'(memread_a), 32'd0);
      #1 rst = 1'b0;
      repeat (5) tick();
      check("t5_no_done", 32'(done_cnt_a), 32'd0);
      clear_log();
      pulse_start_a();
      check("t5_restart_addr", address_a, BASE_A);
      wait_done_a("t5_done_seen");
      check_rx_ab("t5_byte");

      // 6: single-word instance at BASE 0x40
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      repeat (10) tick();
      check("t6_count", 32'(rxb_q.size()), 32'd4);
      if (rxb_q.size() == 4) begin
         check("t6_byte0", 32'(rxb_q[0]), 32'hDE);
         check("t6_byte1", 32'(rxb_q[1]), 32'hAD);
         check("t6_byte2", 32'(rxb_q[2]), 32'hBE);
         check("t6_byte3", 32'(rxb_q[3]), 32'hEF);
      end
      check("t6_memread_cycles", 32'(memread_cnt_b), 32'd1);
      check("t6_done_count", 32'(done_cnt_b), 32'd1);
      check("t6_done_after_last", 32'(done_cyc_b - last_xfer_b), 32'd1);

      // 7: randomized start/ready/memory traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if (exp_q.size() == 0 && $urandom_range(0, 3) == 0) begin
            mem_a[0] = $urandom;
            mem_a[1] = $urandom;
         end
         start_a = ($urandom_range(0, 7) == 0);
         ready_a = ($urandom_range(0, 3) != 0);
         tick();
      end
      start_a = 1'b0;
      ready_a = 1'b1;
      repeat (30) tick();
      check("t7_final_idle", 32'(exp_q.size() == 0 && !busy_a), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

endmodule
